yarvi_div_seq: RTL
==================

YARVI_DIV_SEQ -- requirements
Module: yarvi_div_seq

Interface
REQ-001 clock  in  1  sole clock; all state updates on rising edge.
REQ-002 reset_n  in  1  reset, synchronous, active-low.
REQ-003 start  in  1  valid M-extension divide/remainder op presented by EX this cycle.
REQ-004 funct3  in  3  4=DIV, 5=DIVU, 6=REM, 7=REMU; other values with start=1 ignored.
REQ-005 op_w  in  1  1 = RV64 W-form (DIVW/DIVUW/REMW/REMUW), operate on bits [31:0].
REQ-006 rs1  in  64  dividend (already forwarded).
REQ-007 rs2  in  64  divisor (already forwarded).
REQ-008 rd  in  5  destination register.
REQ-009 flush  in  1  pipeline restart; abandons any in-flight op.
REQ-010 busy  out  1  operation in progress; EX/fetch SHALL stall while high.
REQ-011 done  out  1  one-cycle pulse, result valid.
REQ-012 wb_en  out  1  write-back enable, = done & (wb_rd != 0).
REQ-013 wb_val  out  64  result, held until next done.
REQ-014 wb_rd  out  5  destination of result, held until next done.

Function
REQ-015 States: IDLE, RUN, FIX; busy = (state != IDLE).
REQ-016 IDLE: start=1, flush=0, funct3[2]=1 -> accept on that edge (edge 0); latch funct3, op_w, rd, operand magnitudes and sign flags.
REQ-017 Signed ops use absolute values; quotient negated iff operand signs differ; remainder takes dividend sign.
REQ-018 W-form: operands taken from [31:0], sign- (signed ops) or zero- (unsigned ops) extended; 32-bit result sign-extended to 64 bits.
REQ-019 Divisor zero at accept: no RUN; done after edge 1; quotient = all ones (W: 0xFFFF_FFFF_FFFF_FFFF); remainder = dividend (W: sign-extended rs1[31:0]).
REQ-020 Signed overflow (dividend most-negative, divisor -1, at 64 or 32 bits per op_w): done after edge 1; quotient = dividend; remainder = 0.
REQ-021 Otherwise IDLE->RUN; restoring division, one quotient bit per cycle; iteration counter loaded with 63 (W: 31), decrements each RUN edge.
REQ-022 RUN->FIX on the edge where counter is 0; FIX applies sign correction and selects quotient/remainder, then ->IDLE.
REQ-023 Latency: done high after edge 65 (64-bit) or edge 33 (W); exactly one cycle.
REQ-024 start while busy=1 ignored; no second accept until state IDLE.
REQ-025 Accept is legal in the cycle done=1 (state is IDLE); back-to-back ops lose no cycles.
REQ-026 flush=1 any cycle: state->IDLE next edge, no done/wb_en for that op; wb_val/wb_rd unchanged.
REQ-027 flush and start same cycle: flush wins, op not accepted.
REQ-028 flush in FIX cycle suppresses done.
REQ-029 rd=0: done pulses, wb_en stays 0.

Reset
REQ-030 reset_n=0 at an edge: state IDLE, counter 0, busy 0, done 0, wb_en 0, wb_val 0, wb_rd 0; overrides start and flush.
REQ-031 Reset mid-operation abandons op; no done after reset_n returns high.
REQ-032 First accept possible on the first edge with reset_n=1.

Verification
REQ-033 DIVU rs1=100 rs2=7 rd=5 -> busy edges 1..65, done+wb_en after edge 65, wb_val=14, wb_rd=5; REMU same -> 2.
REQ-034 DIV rs1=-7 rs2=2 -> 0xFFFF_FFFF_FFFF_FFFD; REM -> 0xFFFF_FFFF_FFFF_FFFF.
REQ-035 DIV rs1=5 rs2=0 -> done after edge 1, wb_val=0xFFFF_FFFF_FFFF_FFFF; REM -> 5.
REQ-036 DIV rs1=0x8000_0000_0000_0000 rs2=-1 -> done after edge 1, wb_val=0x8000_0000_0000_0000; REM -> 0.
REQ-037 DIVW rs1=0x0000_0000_FFFF_FFF9 rs2=2 -> done after edge 33, wb_val=0xFFFF_FFFF_FFFF_FFFD.
REQ-038 DIVU 100/7, flush in RUN cycle 10 -> busy 0 next cycle, no done; repeat with reset_n=0 at cycle 10 -> all outputs 0, no done.

Source files
------------

// File: rtl/yarvi_div_seq_if.sv
// Handshake/bus bundle between the EX stage and the sequential divider.
interface yarvi_div_seq_if;
  logic        start;
  logic [2:0]  funct3;
  logic        op_w;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic [4:0]  rd;
  logic        flush;
  logic        busy;
  logic        done;
  logic        wb_en;
  logic [63:0] wb_val;
  logic [4:0]  wb_rd;

  modport master (
    output start, funct3, op_w, rs1, rs2, rd, flush,
    input  busy, done, wb_en, wb_val, wb_rd
  );

  modport slave (
    input  start, funct3, op_w, rs1, rs2, rd, flush,
    output busy, done, wb_en, wb_val, wb_rd
  );
endinterface

// File: rtl/yarvi_div_seq.sv
// Sequential RV64 M-extension divider: restoring division, one quotient bit
// per cycle, with early completion for divide-by-zero and signed overflow.
module yarvi_div_seq (
  input  logic           clock,
  input  logic           reset_n,
  yarvi_div_seq_if.slave dif
);
  localparam int unsigned XLEN  = 64;
  localparam int unsigned HALF  = 32;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned RD_W  = 5;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             sel_rem_q, sel_rem_d;
  logic             op_w_q, op_w_d;
  logic [RD_W-1:0]  rd_q, rd_d;
  logic             done_q, done_d;
  logic             wb_en_q, wb_en_d;
  logic [XLEN-1:0]  wb_val_q, wb_val_d;
  logic [RD_W-1:0]  wb_rd_q, wb_rd_d;

  logic             sgn, a_neg, b_neg, div_zero, ovf;
  logic [XLEN-1:0]  a_ext, b_ext, a_mag, b_mag, min_neg;

  // Operand extension, magnitudes and special-case detection at accept time
  always_comb begin
    sgn = ~dif.funct3[0];
    if (dif.op_w) begin
      a_ext   = sgn ? {{HALF{dif.rs1[HALF-1]}}, dif.rs1[HALF-1:0]}
                    : {{HALF{1'b0}}, dif.rs1[HALF-1:0]};
      b_ext   = sgn ? {{HALF{dif.rs2[HALF-1]}}, dif.rs2[HALF-1:0]}
                    : {{HALF{1'b0}}, dif.rs2[HALF-1:0]};
      min_neg = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};
    end else begin
      a_ext   = dif.rs1;
      b_ext   = dif.rs2;
      min_neg = {1'b1, {(XLEN-1){1'b0}}};
    end
    a_neg    = sgn & a_ext[XLEN-1];
    b_neg    = sgn & b_ext[XLEN-1];
    a_mag    = a_neg ? XLEN'(-a_ext) : a_ext;
    b_mag    = b_neg ? XLEN'(-b_ext) : b_ext;
    div_zero = (b_ext == '0);
    ovf      = sgn & (a_ext == min_neg) & (b_ext == '1);
  end

  logic [XLEN:0]   shifted;
  logic            fits;
  logic [XLEN-1:0] q_fix, r_fix, sel, result;

  // Restoring step and final sign correction / result selection
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    fits    = (shifted >= {1'b0, dvs_q});
    q_fix   = q_neg_q ? XLEN'(-quo_q) : quo_q;
    r_fix   = r_neg_q ? XLEN'(-rem_q) : rem_q;
    sel     = sel_rem_q ? r_fix : q_fix;
    result  = op_w_q ? {{HALF{sel[HALF-1]}}, sel[HALF-1:0]} : sel;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    sel_rem_d = sel_rem_q;
    op_w_d    = op_w_q;
    rd_d      = rd_q;
    done_d    = 1'b0;
    wb_en_d   = 1'b0;
    wb_val_d  = wb_val_q;
    wb_rd_d   = wb_rd_q;

    case (state_q)
      S_IDLE: begin
        if (dif.start && dif.funct3[2]) begin
          op_w_d    = dif.op_w;
          sel_rem_d = dif.funct3[1];
          rd_d      = dif.rd;
          dvs_d     = b_mag;
          cnt_d     = dif.op_w ? CNT_W'(HALF - 1) : CNT_W'(XLEN - 1);
          // Special cases preload final values with no sign fix-up
          if (div_zero) begin
            state_d = S_FIX;
            quo_d   = '1;
            rem_d   = a_ext;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
          end else if (ovf) begin
            state_d = S_FIX;
            quo_d   = a_ext;
            rem_d   = '0;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
          end else begin
            state_d = S_RUN;
            quo_d   = dif.op_w ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
            rem_d   = '0;
            q_neg_d = a_neg ^ b_neg;
            r_neg_d = a_neg;
          end
        end
      end
      S_RUN: begin
        quo_d = {quo_q[XLEN-2:0], fits};
        rem_d = fits ? XLEN'(shifted - {1'b0, dvs_q}) : shifted[XLEN-1:0];
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_FIX: begin
        state_d  = S_IDLE;
        done_d   = 1'b1;
        wb_en_d  = (rd_q != '0);
        wb_val_d = result;
        wb_rd_d  = rd_q;
      end
      default: state_d = S_IDLE;
    endcase

    // Pipeline restart abandons the op, including one sitting in FIX
    if (dif.flush) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      done_d   = 1'b0;
      wb_en_d  = 1'b0;
      wb_val_d = wb_val_q;
      wb_rd_d  = wb_rd_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      sel_rem_q <= 1'b0;
      op_w_q    <= 1'b0;
      rd_q      <= '0;
      done_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_val_q  <= '0;
      wb_rd_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      sel_rem_q <= sel_rem_d;
      op_w_q    <= op_w_d;
      rd_q      <= rd_d;
      done_q    <= done_d;
      wb_en_q   <= wb_en_d;
      wb_val_q  <= wb_val_d;
      wb_rd_q   <= wb_rd_d;
    end
  end

  assign dif.busy   = (state_q != S_IDLE);
  assign dif.done   = done_q;
  assign dif.wb_en  = wb_en_q;
  assign dif.wb_val = wb_val_q;
  assign dif.wb_rd  = wb_rd_q;
endmodule
